regfile_sb: RTL and testbench

Parametrised register file with a write scoreboard. It is the successor to the fixed 16x16 register file in the pipelined core. It sits in the decode stage and adds three things: write-through bypass from writeback, per-register in-flight write tracking, and a RAW/WAW stall output, so the core no longer needs nop padding between dependent instructions. A flush input discards in-flight tracking on jump, jr or taken branch.

---
 rtl/regfile_sb.sv | 125 ++++++++++++
 tb/tb_regfile_sb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write-through bypass and a
// per-register in-flight write scoreboard producing a RAW/WAW issue stall.
module regfile_sb #(
    parameter int unsigned DSIZE    = 16,
    parameter int unsigned ASIZE    = 4,
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned R0_ZERO  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ASIZE-1:0]        raddr1,
    input  logic [ASIZE-1:0]        raddr2,
    output logic [DSIZE-1:0]        rdata1,
    output logic [DSIZE-1:0]        rdata2,
    input  logic                    issue_valid,
    input  logic                    issue_wen,
    input  logic [ASIZE-1:0]        issue_waddr,
    output logic                    stall,
    input  logic                    flush,
    input  logic                    wen,
    input  logic [ASIZE-1:0]        waddr,
    input  logic [DSIZE-1:0]        wdata,
    output logic [(1<<ASIZE)-1:0]   busy
);

    localparam int unsigned NREG = 1 << ASIZE;
    localparam int unsigned CW   = 4;
    localparam logic [CW-1:0] LAT = CW'(PIPE_LAT);
    localparam logic [CW-1:0] ONE = CW'(1);

    // Register 0 is excluded from storage, tracking and hazards when hardwired to zero.
    function automatic logic tracked(input logic [ASIZE-1:0] a);
        return !((R0_ZERO != 0) && (a == '0));
    endfunction

    logic [DSIZE-1:0] mem_q  [NREG];
    logic [CW-1:0]    cnt_q  [NREG];
    logic [CW-1:0]    cnt_d  [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [NREG-1:0]  pend_c;
    logic             accept_c;
    logic             load_c;

    assign busy = busy_q;

    // Storage write from writeback.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wen && tracked(waddr)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port 1: zero register, then bypass from writeback, then storage.
    always_comb begin
        rdata1 = mem_q[raddr1];
        if (!rst || !tracked(raddr1)) begin
            rdata1 = '0;
        end else if (wen && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rdata2 = mem_q[raddr2];
        if (!rst || !tracked(raddr2)) begin
            rdata2 = '0;
        end else if (wen && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

    // Pending = write still two or more cycles away; counter 1 is covered by the bypass.
    always_comb begin
        pend_c = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            pend_c[i] = (cnt_q[i] > ONE) && tracked(ASIZE'(i));
        end
    end

    // Issue stall on RAW (either read port) or WAW (destination), and acceptance.
    always_comb begin
        stall    = rst & issue_valid &
                   (pend_c[raddr1] | pend_c[raddr2] | (issue_wen & pend_c[issue_waddr]));
        accept_c = issue_valid & ~stall;
        load_c   = accept_c & issue_wen & tracked(issue_waddr);
    end

    // Counter next state: flush clears, accepted write loads, otherwise count down.
    always_comb begin
        busy_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (load_c && (issue_waddr == ASIZE'(i))) begin
                cnt_d[i] = LAT;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - ONE;
            end
            busy_d[i] = (cnt_d[i] != '0);
        end
    end

    // Scoreboard counters and busy flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: default configuration plus a
// 32-bit / 32-register / PIPE_LAT=5 instance.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst;

    // Default instance (DSIZE=16, ASIZE=4, PIPE_LAT=3, R0_ZERO=1)
    logic [3:0]  raddr1, raddr2, issue_waddr, waddr;
    logic [15:0] rdata1, rdata2, wdata;
    logic        issue_valid, issue_wen, stall, flush, wen;
    logic [15:0] busy;

    // Wide instance (DSIZE=32, ASIZE=5, PIPE_LAT=5)
    logic [4:0]  b_raddr1, b_raddr2, b_issue_waddr, b_waddr;
    logic [31:0] b_rdata1, b_rdata2, b_wdata;
    logic        b_issue_valid, b_issue_wen, b_stall, b_flush, b_wen;
    logic [31:0] b_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_waddr(issue_waddr),
        .stall(stall), .flush(flush),
        .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy)
    );

    regfile_sb #(.DSIZE(32), .ASIZE(5), .PIPE_LAT(5), .R0_ZERO(1)) u_dut_w (
        .clk(clk), .rst(rst),
        .raddr1(b_raddr1), .raddr2(b_raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2),
        .issue_valid(b_issue_valid), .issue_wen(b_issue_wen), .issue_waddr(b_issue_waddr),
        .stall(b_stall), .flush(b_flush),
        .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata), .busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_a();
        raddr1 = '0; raddr2 = '0; issue_valid = 1'b0; issue_wen = 1'b0;
        issue_waddr = '0; flush = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
    endtask

    task automatic idle_b();
        b_raddr1 = '0; b_raddr2 = '0; b_issue_valid = 1'b0; b_issue_wen = 1'b0;
        b_issue_waddr = '0; b_flush = 1'b0; b_wen = 1'b0; b_waddr = '0; b_wdata = '0;
    endtask

    // Inputs change just after the falling edge; the next rising edge consumes them.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle_a();
        idle_b();

        // Reset: outputs quiet, bypass suppressed, writes dropped.
        next_cycle();
        issue_valid = 1'b1; raddr1 = 4'd5; wen = 1'b1; waddr = 4'd5; wdata = 16'h1111;
        #1;
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_rdata1", 64'(rdata1), 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_busy_w", 64'(b_busy), 64'h0);
        next_cycle();
        idle_a();
        rst = 1'b1;

        // Plain write then read on both ports.
        next_cycle();
        wen = 1'b1; waddr = 4'd5; wdata = 16'h1234;
        next_cycle();
        idle_a(); raddr1 = 4'd5; raddr2 = 4'd5;
        #1;
        check_eq("rd1_r5", 64'(rdata1), 64'h1234);
        check_eq("rd2_r5", 64'(rdata2), 64'h1234);

        // Second reset clears storage.
        next_cycle();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1; raddr1 = 4'd5;
        #1;
        check_eq("r5_after_rst", 64'(rdata1), 64'h0);

        // Write-through bypass and r0 hardwired to zero.
        next_cycle();
        idle_a(); wen = 1'b1; waddr = 4'd7; wdata = 16'hBEEF; raddr1 = 4'd7; raddr2 = 4'd6;
        #1;
        check_eq("bypass_rd1", 64'(rdata1), 64'hBEEF);
        check_eq("bypass_rd2_other", 64'(rdata2), 64'h0);
        next_cycle();
        idle_a(); wen = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; raddr1 = 4'd0; raddr2 = 4'd7;
        #1;
        check_eq("r0_bypass_zero", 64'(rdata1), 64'h0);
        check_eq("r7_stored", 64'(rdata2), 64'hBEEF);
        next_cycle();
        idle_a(); raddr1 = 4'd0;
        #1;
        check_eq("r0_stored_zero", 64'(rdata1), 64'h0);

        // Issue to r0 is never tracked.
        issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 4'd0;
        next_cycle();
        idle_a(); issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 4'd0;
        #1;
        check_eq("r0_untracked_busy", 64'(busy), 64'h0);
        check_eq("r0_untracked_stall", 64'(stall), 64'd0);

        // RAW on r3 with PIPE_LAT=3.
        next_cycle();
        idle_a(); issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 4'd3;
        #1;
        check_eq("raw_c0_stall", 64'(stall), 64'd0);
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            idle_a(); issue_valid = 1'b1; raddr1 = 4'd3;
            #1;
            check_eq($sformatf("raw_c%0d_stall", k), 64'(stall), 64'd1);
            check_eq($sformatf("raw_c%0d_busy3", k), 64'(busy[3]), 64'd1);
        end
        next_cycle();
        idle_a(); issue_valid = 1'b1; raddr1 = 4'd3; wen = 1'b1; waddr = 4'd3; wdata = 16'h0042;
        #1;
        check_eq("raw_c3_stall", 64'(stall), 64'd0);
        check_eq("raw_c3_rdata1", 64'(rdata1), 64'h0042);
        check_eq("raw_c3_busy3", 64'(busy[3]), 64'd1);
        next_cycle();
        idle_a(); raddr1 = 4'd3;
        #1;
        check_eq("raw_c4_busy3", 64'(busy[3]), 64'd0);
        check_eq("raw_c4_stored", 64'(rdata1), 64'h0042);

        // WAW on r4 and re-issue when counter is 1.
        next_cycle();
        idle_a(); issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 4'd4;
        #1;
        check_eq("waw_c0_stall", 64'(stall), 64'd0);
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            idle_a(); issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 4'd4;
            #1;
            check_eq($sformatf("waw_c%0d_stall", k), 64'(stall), 64'd1);
        end
        next_cycle();
        idle_a(); issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 4'd4;
        wen = 1'b1; waddr = 4'd4; wdata = 16'h0404;
        #1;
        check_eq("waw_c3_accept", 64'(stall), 64'd0);
        next_cycle();
        idle_a(); issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 4'd4; raddr2 = 4'd0;
        #1;
        check_eq("waw_c4_busy4", 64'(busy[4]), 64'd1);
        check_eq("waw_c4_reloaded_stall", 64'(stall), 64'd1);
        issue_valid = 1'b0; raddr1 = 4'd4;
        #1;
        check_eq("waw_c4_written", 64'(rdata1), 64'h0404);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            idle_a();
        end
        #1;
        check_eq("waw_drained", 64'(busy), 64'h0);

        // Flush discards r1/r2 tracking and the r6 issue presented with it.
        next_cycle();
        idle_a(); issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 4'd1;
        next_cycle();
        idle_a(); issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 4'd2;
        #1;
        check_eq("flush_r2_accept", 64'(stall), 64'd0);
        next_cycle();
        idle_a(); issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 4'd6; flush = 1'b1;
        #1;
        check_eq("flush_busy_before", 64'(busy), 64'h0006);
        next_cycle();
        idle_a(); issue_valid = 1'b1; raddr1 = 4'd1; raddr2 = 4'd2;
        #1;
        check_eq("flush_busy_after", 64'(busy), 64'h0);
        check_eq("flush_stall_after", 64'(stall), 64'd0);

        // Reset taken mid-stall.
        next_cycle();
        idle_a(); issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 4'd9;
        next_cycle();
        idle_a(); issue_valid = 1'b1; raddr1 = 4'd9;
        #1;
        check_eq("rstmid_stall", 64'(stall), 64'd1);
        rst = 1'b0;
        #1;
        check_eq("rstmid_stall_in_rst", 64'(stall), 64'd0);
        next_cycle();
        rst = 1'b1;
        #1;
        check_eq("rstmid_busy", 64'(busy), 64'h0);
        check_eq("rstmid_stall_after", 64'(stall), 64'd0);
        idle_a();

        // Wide instance: RAW stall lasts exactly PIPE_LAT-1 = 4 cycles, 32-bit bypass.
        next_cycle();
        idle_b(); b_issue_valid = 1'b1; b_issue_wen = 1'b1; b_issue_waddr = 5'd17;
        #1;
        check_eq("w_c0_stall", 64'(b_stall), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            idle_b(); b_issue_valid = 1'b1; b_raddr1 = 5'd17;
            #1;
            check_eq($sformatf("w_c%0d_stall", k), 64'(b_stall), 64'd1);
        end
        next_cycle();
        idle_b(); b_issue_valid = 1'b1; b_raddr1 = 5'd17;
        b_wen = 1'b1; b_waddr = 5'd17; b_wdata = 32'hDEAD_BEEF;
        #1;
        check_eq("w_c5_stall", 64'(b_stall), 64'd0);
        check_eq("w_c5_bypass", 64'(b_rdata1), 64'hDEAD_BEEF);
        check_eq("w_c5_busy17", 64'(b_busy[17]), 64'd1);
        next_cycle();
        idle_b(); b_raddr1 = 5'd17; b_wen = 1'b1; b_waddr = 5'd30;
        b_wdata = 32'hA5A5_0001; b_raddr2 = 5'd30;
        #1;
        check_eq("w_c6_busy", 64'(b_busy), 64'h0);
        check_eq("w_c6_stored", 64'(b_rdata1), 64'hDEAD_BEEF);
        check_eq("w_bypass2", 64'(b_rdata2), 64'hA5A5_0001);
        next_cycle();
        idle_b();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
